// File: rtl/gate_truth_sweep_ctrl_pkg.sv
// Shared constants for the gate truth-table sweep controller.
package gate_truth_sweep_ctrl_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned VEC_N = 4;

  // FSM state encodings (binary)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Expected gate output per input vector, bit index = {a,b}
  localparam logic [VEC_N-1:0] TT_AND  = 4'b1000;
  localparam logic [VEC_N-1:0] TT_OR   = 4'b1110;
  localparam logic [VEC_N-1:0] TT_XOR  = 4'b0110;
  localparam logic [VEC_N-1:0] TT_NAND = 4'b0111;

  // Drive pair presented to the gate under check
  typedef struct packed {
    logic a;
    logic b;
  } gate_drv_t;

  // Map a vector index onto the gate inputs: a is the MSB, b the LSB
  function automatic gate_drv_t vec_drive(input logic [1:0] idx);
    gate_drv_t d;
    d.a = idx[1];
    d.b = idx[0];
    return d;
  endfunction

endpackage

// File: rtl/gate_truth_sweep_ctrl_if.sv
// Control/status and gate-side signals of the sweep controller.
interface gate_truth_sweep_ctrl_if;
  import gate_truth_sweep_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic             gate_a;
  logic             gate_b;
  logic             gate_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [VEC_N-1:0] err_vec;

  // Controller side
  modport master (
    input  start, abort, gate_y,
    output gate_a, gate_b, busy, done, pass, err_vec
  );

  // Environment side: requester plus the gate under check
  modport slave (
    output start, abort, gate_y,
    input  gate_a, gate_b, busy, done, pass, err_vec
  );

endinterface

// File: rtl/gate_truth_sweep_ctrl_hold_counter.sv
// Loadable up-counter timing how long each vector is held on the gate.
module gate_truth_sweep_ctrl_hold_counter
  import gate_truth_sweep_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority over count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High on the counting cycle that completes the hold window
  assign tc_c_o = en_i && ((cnt_q + CNT_W'(1)) == CNT_W'(HOLD_CYCLES));

endmodule

// File: rtl/gate_truth_sweep_ctrl.sv
// Sweeps a 2-input gate through all four vectors and checks it against TRUTH.
module gate_truth_sweep_ctrl
  import gate_truth_sweep_ctrl_pkg::*;
#(
  parameter int unsigned      HOLD_CYCLES = 2,
  parameter logic [VEC_N-1:0] TRUTH       = TT_AND
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gate_truth_sweep_ctrl_if.master bus
);

  if (HOLD_CYCLES == 0 || HOLD_CYCLES > 255) begin : g_hold_illegal
    $error("gate_truth_sweep_ctrl: HOLD_CYCLES=%0d outside 1..255", HOLD_CYCLES);
  end

  logic [1:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [VEC_N-1:0] err_q, err_d;
  gate_drv_t        gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             cnt_clr_c;
  logic             cnt_en_c;
  logic             hold_tc_c;

  gate_truth_sweep_ctrl_hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr_c),
    .en_i   (cnt_en_c),
    .tc_c_o (hold_tc_c)
  );

  // Next-state, vector index, error capture and registered-output values
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d   = ST_DRIVE;
          idx_d     = '0;
          err_d     = '0;
          cnt_clr_c = 1'b1;
        end
      end
      ST_DRIVE: begin
        cnt_en_c = 1'b1;
        if (hold_tc_c) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        err_d[idx_q] = (bus.gate_y != TRUTH[idx_q]);
        cnt_clr_c    = 1'b1;
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort beats everything, including a same-cycle start; results so far are kept
    if (bus.abort) begin
      state_d   = ST_IDLE;
      idx_d     = idx_q;
      err_d     = err_q;
      cnt_clr_c = 1'b1;
    end

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    gate_d = busy_d ? vec_drive(idx_d) : '0;
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      gate_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.gate_a  = gate_q.a;
  assign bus.gate_b  = gate_q.b;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_vec = err_q;

endmodule

// File: tb/tb_gate_truth_sweep_ctrl.sv
// Scoreboard bench: two controllers (AND and OR truth tables) share stimulus and a gate model.
module tb_gate_truth_sweep_ctrl;
  import gate_truth_sweep_ctrl_pkg::*;

  localparam int HOLD = 2;
  localparam int LAT  = 4 * (HOLD + 1) + 1;
  localparam logic [3:0] EXP_AND = 4'b1000;
  localparam logic [3:0] EXP_OR  = 4'b1110;
  localparam int M_AND = 0, M_STUCK0 = 1, M_OR = 2, M_NAND = 3;

  typedef struct {
    logic [3:0] e0;
    logic       p0;
    logic [3:0] e1;
    logic       p1;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   mode = M_AND;
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  logic done_prev = 1'b0;
  exp_t sb_q[$];

  function automatic logic gate_fn(input int m, input logic a, input logic b);
    case (m)
      M_AND:    return a & b;
      M_STUCK0: return 1'b0;
      M_OR:     return a | b;
      default:  return ~(a & b);
    endcase
  endfunction

  function automatic logic [3:0] exp_err(input int m, input logic [3:0] tt);
    logic [3:0] r;
    logic [1:0] vv;
    r = '0;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      r[v] = (gate_fn(m, vv[1], vv[0]) != tt[v]);
    end
    return r;
  endfunction

  gate_truth_sweep_ctrl_if u_if0 ();
  gate_truth_sweep_ctrl_if u_if1 ();

  assign u_if0.start  = start;
  assign u_if0.abort  = abort;
  assign u_if0.gate_y = gate_fn(mode, u_if0.gate_a, u_if0.gate_b);
  assign u_if1.start  = start;
  assign u_if1.abort  = abort;
  assign u_if1.gate_y = gate_fn(mode, u_if1.gate_a, u_if1.gate_b);

  gate_truth_sweep_ctrl #(.HOLD_CYCLES(HOLD), .TRUTH(TT_AND)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(u_if0)
  );
  gate_truth_sweep_ctrl #(.HOLD_CYCLES(HOLD), .TRUTH(TT_OR)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(u_if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // Scoreboard: on each rising done, pop the oldest expectation and compare
  always @(negedge clk) begin
    if (u_if0.done && !done_prev) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected_done: got done=1 with no sweep pending");
      end else begin
        e = sb_q.pop_front();
        total++;
        if (u_if0.err_vec !== e.e0) begin
          bad++; $display("FAIL sb_err0: got %b expected %b", u_if0.err_vec, e.e0);
        end
        total++;
        if (u_if0.pass !== e.p0) begin
          bad++; $display("FAIL sb_pass0: got %b expected %b", u_if0.pass, e.p0);
        end
        total++;
        if (u_if1.err_vec !== e.e1) begin
          bad++; $display("FAIL sb_err1: got %b expected %b", u_if1.err_vec, e.e1);
        end
        total++;
        if (u_if1.pass !== e.p1) begin
          bad++; $display("FAIL sb_pass1: got %b expected %b", u_if1.pass, e.p1);
        end
        total++;
        if ((edge_cnt - e.t0) != LAT) begin
          bad++; $display("FAIL sb_latency: got %0d edges expected %0d", edge_cnt - e.t0, LAT);
        end
      end
    end
    done_prev = u_if0.done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push expectation, then present start for exactly one edge
  task automatic start_sweep(input int m);
    exp_t e;
    mode = m;
    e.e0 = exp_err(m, EXP_AND);
    e.p0 = (e.e0 == 4'b0000);
    e.e1 = exp_err(m, EXP_OR);
    e.p1 = (e.e1 == 4'b0000);
    e.t0 = edge_cnt;
    sb_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!u_if0.done && n < 4 * LAT) begin
      tick();
      n++;
    end
    total++;
    if (!u_if0.done) begin
      bad++; $display("FAIL %s_timeout: done=0 after %0d cycles, expected 1", tag, n);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({u_if0.gate_a, u_if0.gate_b, u_if0.busy, u_if0.done, u_if0.pass, u_if0.err_vec} !== 9'b0) begin
      bad++; $display("FAIL reset_dut0: got %b expected 0", {u_if0.gate_a, u_if0.gate_b,
        u_if0.busy, u_if0.done, u_if0.pass, u_if0.err_vec});
    end
    total++;
    if ({u_if1.gate_a, u_if1.gate_b, u_if1.busy, u_if1.done, u_if1.pass, u_if1.err_vec} !== 9'b0) begin
      bad++; $display("FAIL reset_dut1: got %b expected 0", {u_if1.gate_a, u_if1.gate_b,
        u_if1.busy, u_if1.done, u_if1.pass, u_if1.err_vec});
    end
    #3 rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if ({u_if0.gate_a, u_if0.gate_b, u_if0.busy, u_if0.done} !== 4'b0) begin
      bad++; $display("FAIL reset_idle: got %b expected 0000",
        {u_if0.gate_a, u_if0.gate_b, u_if0.busy, u_if0.done});
    end
  endtask

  // Cycle-by-cycle waveform of a clean AND sweep
  task automatic test_and_sweep();
    start_sweep(M_AND);
    for (int k = 1; k <= LAT; k++) begin
      logic [3:0] exp_w;
      logic [3:0] got_w;
      if (k < LAT) exp_w = {2'((k - 1) / (HOLD + 1)), 1'b1, 1'b0};
      else         exp_w = 4'b0001;
      got_w = {u_if0.gate_a, u_if0.gate_b, u_if0.busy, u_if0.done};
      total++;
      if (got_w !== exp_w) begin
        bad++; $display("FAIL and_wave_edge%0d: got ab/busy/done=%b expected %b", k, got_w, exp_w);
      end
      if (k < LAT) tick();
    end
    tick();
  endtask

  task automatic test_stuck0();
    start_sweep(M_STUCK0);
    total++;
    if ({u_if0.busy, u_if0.done} !== 2'b10) begin
      bad++; $display("FAIL restart_from_done: got busy/done=%b expected 10", {u_if0.busy, u_if0.done});
    end
    wait_done("stuck0");
  endtask

  task automatic test_or_gate();
    start_sweep(M_OR);
    total++;
    if (u_if0.err_vec !== 4'b0000) begin
      bad++; $display("FAIL err_clear0: got %b expected 0000", u_if0.err_vec);
    end
    total++;
    if (u_if1.err_vec !== 4'b0000) begin
      bad++; $display("FAIL err_clear1: got %b expected 0000", u_if1.err_vec);
    end
    wait_done("or_gate");
  endtask

  task automatic test_abort();
    start_sweep(M_NAND);
    repeat (2 * (HOLD + 1)) tick();
    total++;
    if ({u_if0.gate_a, u_if0.gate_b, u_if0.busy} !== 3'b101) begin
      bad++; $display("FAIL abort_pre_vec2: got %b expected 101", {u_if0.gate_a, u_if0.gate_b, u_if0.busy});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    void'(sb_q.pop_back());
    total++;
    if ({u_if0.gate_a, u_if0.gate_b, u_if0.busy, u_if0.done} !== 4'b0) begin
      bad++; $display("FAIL abort_outputs: got %b expected 0000",
        {u_if0.gate_a, u_if0.gate_b, u_if0.busy, u_if0.done});
    end
    total++;
    if (u_if0.err_vec !== (exp_err(M_NAND, EXP_AND) & 4'b0011)) begin
      bad++; $display("FAIL abort_err0: got %b expected %b", u_if0.err_vec, exp_err(M_NAND, EXP_AND) & 4'b0011);
    end
    total++;
    if (u_if1.err_vec !== (exp_err(M_NAND, EXP_OR) & 4'b0011)) begin
      bad++; $display("FAIL abort_err1: got %b expected %b", u_if1.err_vec, exp_err(M_NAND, EXP_OR) & 4'b0011);
    end
    repeat (3) tick();
    total++;
    if ({u_if0.busy, u_if0.done} !== 2'b00) begin
      bad++; $display("FAIL abort_stays_idle: got busy/done=%b expected 00", {u_if0.busy, u_if0.done});
    end
    start_sweep(M_AND);
    total++;
    if (u_if0.err_vec !== 4'b0000) begin
      bad++; $display("FAIL abort_restart_clear: got %b expected 0000", u_if0.err_vec);
    end
    wait_done("abort_rerun");
    // abort and start together from DONE: abort must win
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if ({u_if0.busy, u_if0.done} !== 2'b00) begin
      bad++; $display("FAIL abort_beats_start: got busy/done=%b expected 00", {u_if0.busy, u_if0.done});
    end
    total++;
    if (u_if1.err_vec !== exp_err(M_AND, EXP_OR)) begin
      bad++; $display("FAIL abort_keeps_err: got %b expected %b", u_if1.err_vec, exp_err(M_AND, EXP_OR));
    end
  endtask

  task automatic test_start_busy();
    start_sweep(M_OR);
    repeat (HOLD + 1) tick();
    total++;
    if ({u_if0.gate_a, u_if0.gate_b} !== 2'b01) begin
      bad++; $display("FAIL busy_pre_vec1: got %b expected 01", {u_if0.gate_a, u_if0.gate_b});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({u_if0.gate_a, u_if0.gate_b, u_if0.busy} !== 3'b011) begin
      bad++; $display("FAIL busy_start_ignored: got %b expected 011", {u_if0.gate_a, u_if0.gate_b, u_if0.busy});
    end
    wait_done("start_busy");
    start_sweep(M_AND);
    total++;
    if ({u_if0.busy, u_if0.done, u_if0.pass} !== 3'b100) begin
      bad++; $display("FAIL done_rerun: got busy/done/pass=%b expected 100",
        {u_if0.busy, u_if0.done, u_if0.pass});
    end
    wait_done("rerun");
  endtask

  task automatic test_reset_mid_sample();
    start_sweep(M_NAND);
    repeat (5) tick();
    total++;
    if ({u_if0.busy, u_if0.err_vec} !== 5'b1_0001) begin
      bad++; $display("FAIL rst_pre_sample: got %b expected 10001", {u_if0.busy, u_if0.err_vec});
    end
    #2 rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    total++;
    if ({u_if0.gate_a, u_if0.gate_b, u_if0.busy, u_if0.done, u_if0.pass, u_if0.err_vec} !== 9'b0) begin
      bad++; $display("FAIL rst_async0: got %b expected 0", {u_if0.gate_a, u_if0.gate_b,
        u_if0.busy, u_if0.done, u_if0.pass, u_if0.err_vec});
    end
    total++;
    if ({u_if1.gate_a, u_if1.gate_b, u_if1.busy, u_if1.done, u_if1.pass, u_if1.err_vec} !== 9'b0) begin
      bad++; $display("FAIL rst_async1: got %b expected 0", {u_if1.gate_a, u_if1.gate_b,
        u_if1.busy, u_if1.done, u_if1.pass, u_if1.err_vec});
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if ({u_if0.gate_a, u_if0.gate_b, u_if0.busy, u_if0.done, u_if0.err_vec} !== 8'b0) begin
      bad++; $display("FAIL rst_release_idle: got %b expected 0",
        {u_if0.gate_a, u_if0.gate_b, u_if0.busy, u_if0.done, u_if0.err_vec});
    end
  endtask

  initial begin
    test_reset();
    test_and_sweep();
    test_stuck0();
    test_or_gate();
    test_abort();
    test_start_busy();
    test_reset_mid_sample();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
